// File: rtl/config_loader_pkg.sv
// Shared definitions for the fabric configuration bus: feature ids, reserved
// addresses and the loader state encoding.
package config_loader_pkg;

  localparam logic [15:0] CONFIG_SB  = 16'd7;
  localparam logic [15:0] CONFIG_CB0 = 16'd6;
  localparam logic [15:0] CONFIG_CB1 = 16'd5;
  localparam logic [15:0] CONFIG_CLB = 16'd4;

  // No tile decodes the idle address; the end address only terminates a stream.
  localparam logic [31:0] DEF_IDLE_ADDR = 32'hFFFF_FFFF;
  localparam logic [31:0] DEF_END_ADDR  = 32'hFFFF_FFFE;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_ADDR = 3'd1,
    LD_DATA = 3'd2,
    WRITE   = 3'd3,
    DONE    = 3'd4
  } state_t;

  function automatic logic [31:0] make_config_addr(input logic [15:0] feature_id,
                                                   input logic [15:0] tile_id);
    return {feature_id, tile_id};
  endfunction

endpackage

// File: rtl/config_loader_if.sv
// Byte-serial programming port between the external bitstream source and the loader.
interface config_loader_if;
  // A byte moves on every clock edge where in_valid and in_ready are both high;
  // the source holds in_data/in_valid steady until that happens, and in_ready
  // never depends combinationally on in_valid.
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/config_byte_assembler.sv
// Packs eight little-endian bytes into a {data, addr} record and flags the
// 4th (address complete) and 8th (record complete) byte in their transfer cycle.
module config_byte_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        addr_last,
  output logic        record_ready,
  output logic [63:0] record
);

  logic [63:0] rec_q;
  logic [2:0]  idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rec_q <= '0;
      idx_q <= '0;
    end else if (clear) begin
      idx_q <= '0;
    end else if (byte_en) begin
      rec_q[{idx_q, 3'b000} +: 8] <= byte_in;
      idx_q                      <= idx_q + 3'd1;
    end
  end

  // Merged view includes the byte being accepted now, so the FSM can act on it
  // in the same cycle without waiting for the register update.
  always_comb begin
    record = rec_q;
    if (byte_en) record[{idx_q, 3'b000} +: 8] = byte_in;
  end

  assign addr_last    = byte_en && (idx_q == 3'd3);
  assign record_ready = byte_en && (idx_q == 3'd7);

endmodule

// File: rtl/config_loader.sv
// Configuration master: collects records from the byte port and broadcasts
// each one as a config write to every tile in the array.
module config_loader
  import config_loader_pkg::*;
#(
  parameter logic [31:0] IDLE_ADDR    = DEF_IDLE_ADDR,
  parameter logic [31:0] END_ADDR     = DEF_END_ADDR,
  parameter int          WRITE_CYCLES = 1,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  config_loader_if.slave   prog,
  output logic [31:0]      config_addr,
  output logic [31:0]      config_data,
  output logic             config_write,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] write_count,
  output state_t           state
);

  localparam int HOLD_W = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(WRITE_CYCLES - 1);

  logic              byte_en;
  logic              asm_clear;
  logic              addr_last;
  logic              record_ready;
  logic [63:0]       record;
  logic [HOLD_W-1:0] hold_q;

  assign byte_en   = prog.in_valid & prog.in_ready;
  assign asm_clear = start & ((state == IDLE) | (state == DONE));

  config_byte_assembler u_asm (
    .clk          (clk),
    .rst          (reset),
    .clear        (asm_clear),
    .byte_en      (byte_en),
    .byte_in      (prog.in_data),
    .addr_last    (addr_last),
    .record_ready (record_ready),
    .record       (record)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      config_addr   <= IDLE_ADDR;
      config_data   <= '0;
      config_write  <= 1'b0;
      prog.in_ready <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      write_count   <= '0;
      hold_q        <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= LD_ADDR;
            prog.in_ready <= 1'b1;
            busy          <= 1'b1;
            done          <= 1'b0;
            write_count   <= '0;
          end
        end
        LD_ADDR: begin
          if (addr_last) begin
            if (record[31:0] == END_ADDR) begin
              state         <= DONE;
              prog.in_ready <= 1'b0;
              busy          <= 1'b0;
              done          <= 1'b1;
            end else begin
              state <= LD_DATA;
            end
          end
        end
        LD_DATA: begin
          if (record_ready) begin
            state         <= WRITE;
            prog.in_ready <= 1'b0;
            config_addr   <= record[31:0];
            config_data   <= record[63:32];
            config_write  <= 1'b1;
            hold_q        <= HOLD_LAST;
            write_count   <= (write_count == '1) ? write_count : write_count + 1'b1;
          end
        end
        WRITE: begin
          // Tile enables decode config_addr directly, so it must park on the
          // idle address the moment the hold ends.
          if (hold_q == '0) begin
            state         <= LD_ADDR;
            prog.in_ready <= 1'b1;
            config_addr   <= IDLE_ADDR;
            config_write  <= 1'b0;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          config_addr   <= IDLE_ADDR;
          config_write  <= 1'b0;
          prog.in_ready <= 1'b0;
          busy          <= 1'b0;
          done          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: three instances (default, 3-cycle writes, 2-bit
// counter) driven one at a time and checked against a record-level model.
module tb_config_loader;
  import config_loader_pkg::*;

  localparam int N = 3;

  logic clk = 1'b0;
  logic reset;

  logic        start        [N];
  logic [7:0]  in_data      [N];
  logic        in_valid     [N];
  logic        in_ready     [N];
  logic [31:0] config_addr  [N];
  logic [31:0] config_data  [N];
  logic        config_write [N];
  logic        busy         [N];
  logic        done         [N];
  logic [15:0] write_count  [N];
  state_t      state        [N];

  int checks    = 0;
  int failures  = 0;
  int cur       = 0;
  bit mon_en    = 1'b0;
  int wr_cycles = 0;

  logic [63:0] exp_q[$];
  logic [31:0] tile_q [4];
  bit          tile_v [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int G_WC = (g == 1) ? 3 : 1;
    localparam int G_CW = (g == 2) ? 2 : 16;
    config_loader_if prog ();
    logic [G_CW-1:0] wc;

    assign prog.in_data  = in_data[g];
    assign prog.in_valid = in_valid[g];
    assign in_ready[g]   = prog.in_ready;
    assign write_count[g] = 16'(wc);

    config_loader #(.WRITE_CYCLES(G_WC), .CNT_W(G_CW)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start[g]),
      .prog         (prog),
      .config_addr  (config_addr[g]),
      .config_data  (config_data[g]),
      .config_write (config_write[g]),
      .busy         (busy[g]),
      .done         (done[g]),
      .write_count  (wc),
      .state        (state[g])
    );
  end

  function automatic int wc_of(input int d);
    return (d == 1) ? 3 : 1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor and tile model (tile_id 3) for the active instance.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (config_write[cur]) begin
        logic [63:0] e;
        wr_cycles++;
        check("in_ready_during_write", 64'(in_ready[cur]), 64'd0);
        check("write_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("bus_record", {config_addr[cur], config_data[cur]}, e);
        end
        if (config_addr[cur][15:0] == 16'd3 && config_addr[cur][31:16] >= 16'd4
            && config_addr[cur][31:16] <= 16'd7) begin
          tile_q[config_addr[cur][17:16]] = config_data[cur];
          tile_v[config_addr[cur][17:16]] = 1'b1;
        end
      end else begin
        check("bus_idle", 64'(config_addr[cur]), 64'(DEF_IDLE_ADDR));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int t;
    repeat ($urandom_range(max_gap, 0)) @(negedge clk);
    in_data[cur]  = b;
    in_valid[cur] = 1'b1;
    t = 0;
    while (!in_ready[cur] && t < 64) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_wait", 64'(in_ready[cur]), 64'd1);
    @(negedge clk);
    in_valid[cur] = 1'b0;
    in_data[cur]  = 8'($urandom);
  endtask

  task automatic send_word(input logic [31:0] w, input int g);
    for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8], g);
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
    for (int k = 0; k < wc_of(cur); k++) exp_q.push_back({a, d});
  endtask

  task automatic send_record(input logic [31:0] a, input logic [31:0] d, input int g);
    push_exp(a, d);
    send_word(a, g);
    send_word(d, g);
  endtask

  task automatic pulse_start();
    start[cur] = 1'b1;
    @(negedge clk);
    start[cur] = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_addr"},  64'(config_addr[cur]), 64'(DEF_IDLE_ADDR));
    check({tag, "_data"},  64'(config_data[cur]), 64'd0);
    check({tag, "_write"}, 64'(config_write[cur]), 64'd0);
    check({tag, "_ready"}, 64'(in_ready[cur]), 64'd0);
    check({tag, "_busy"},  64'(busy[cur]), 64'd0);
    check({tag, "_done"},  64'(done[cur]), 64'd0);
    check({tag, "_count"}, 64'(write_count[cur]), 64'd0);
    check({tag, "_state"}, 64'(state[cur]), 64'(IDLE));
  endtask

  task automatic check_started(input string tag, input int exp_wc);
    check({tag, "_busy"},  64'(busy[cur]), 64'd1);
    check({tag, "_done"},  64'(done[cur]), 64'd0);
    check({tag, "_ready"}, 64'(in_ready[cur]), 64'd1);
    check({tag, "_count"}, 64'(write_count[cur]), 64'(exp_wc));
    check({tag, "_state"}, 64'(state[cur]), 64'(LD_ADDR));
  endtask

  task automatic check_done(input string tag, input int exp_wc);
    repeat (2) @(negedge clk);
    #1;
    check({tag, "_done"},  64'(done[cur]), 64'd1);
    check({tag, "_busy"},  64'(busy[cur]), 64'd0);
    check({tag, "_ready"}, 64'(in_ready[cur]), 64'd0);
    check({tag, "_count"}, 64'(write_count[cur]), 64'(exp_wc));
    check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [15:0] f;
    logic [15:0] t;
    f = 16'($urandom_range(7, 4));
    t = ($urandom_range(1, 0) == 1) ? 16'd3 : 16'($urandom_range(15, 0));
    return make_config_addr(f, t);
  endfunction

  initial begin
    int base;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] etile [4];
    bit          etv   [4];

    for (int i = 0; i < N; i++) begin
      start[i] = 1'b0; in_valid[i] = 1'b0; in_data[i] = 8'h00;
    end
    for (int f = 0; f < 4; f++) begin tile_q[f] = '0; tile_v[f] = 1'b0; end

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("in_reset");
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("after_reset");
    mon_en = 1'b1;

    // Directed single record then END.
    base = wr_cycles;
    pulse_start();
    check_started("start", 0);
    send_record(32'h0007_0003, 32'h0000_0005, 0);
    send_end_word(0);
    check_done("single", 1);
    check("single_write_cycles", 64'(wr_cycles - base), 64'd1);

    // Same stream with valid gaps; tile 3 sees only SB data=5.
    for (int f = 0; f < 4; f++) begin tile_q[f] = '0; tile_v[f] = 1'b0; end
    base = wr_cycles;
    pulse_start();
    send_record(32'h0007_0003, 32'h0000_0005, 5);
    send_end_word(5);
    check_done("gapped", 1);
    check("gapped_write_cycles", 64'(wr_cycles - base), 64'd1);
    check("tile_sb", {31'(0), tile_v[3], tile_q[3]}, {31'(0), 1'b1, 32'd5});
    for (int f = 0; f < 3; f++) check("tile_other_untouched", 64'(tile_v[f]), 64'd0);

    // Random records; tile 3 model derived from the record list.
    for (int f = 0; f < 4; f++) begin
      tile_q[f] = '0; tile_v[f] = 1'b0; etile[f] = '0; etv[f] = 1'b0;
    end
    base = wr_cycles;
    pulse_start();
    for (int r = 0; r < 6; r++) begin
      a = rand_addr();
      d = $urandom;
      if (a[15:0] == 16'd3) begin etile[a[17:16]] = d; etv[a[17:16]] = 1'b1; end
      send_record(a, d, 3);
    end
    send_end_word(2);
    check_done("random", 6);
    check("random_write_cycles", 64'(wr_cycles - base), 64'd6);
    for (int f = 0; f < 4; f++)
      check("tile_random", {31'(0), tile_v[f], tile_q[f]}, {31'(0), etv[f], etile[f]});

    // Reset in the middle of the data bytes discards the record.
    pulse_start();
    send_word(32'h0006_0001, 1);
    send_byte(8'hAA, 1);
    send_byte(8'hBB, 1);
    reset = 1'b1;
    #1;
    check_reset_vals("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    base = wr_cycles;
    pulse_start();
    send_record(32'h0005_0002, 32'h1234_5678, 1);
    send_end_word(1);
    check_done("post_reset", 1);
    check("post_reset_write_cycles", 64'(wr_cycles - base), 64'd1);

    // start during LD_ADDR is ignored; start in DONE restarts.
    pulse_start();
    send_record(32'h0004_0003, 32'hCAFE_0001, 0);
    push_exp(32'h0006_0009, 32'hCAFE_0002);
    send_byte(8'h09, 0);
    send_byte(8'h00, 0);
    pulse_start();
    check("ignored_start_state", 64'(state[cur]), 64'(LD_ADDR));
    check("ignored_start_count", 64'(write_count[cur]), 64'd1);
    check("ignored_start_busy", 64'(busy[cur]), 64'd1);
    send_byte(8'h06, 0);
    send_byte(8'h00, 0);
    send_word(32'hCAFE_0002, 0);
    send_end_word(0);
    check_done("ignored_start", 2);
    pulse_start();
    check_started("restart", 0);
    send_end_word(0);
    check_done("empty_load", 0);

    // Three-cycle writes.
    cur = 1;
    base = wr_cycles;
    pulse_start();
    for (int r = 0; r < 3; r++) send_record(rand_addr(), $urandom, 2);
    send_end_word(2);
    check_done("hold3", 3);
    check("hold3_write_cycles", 64'(wr_cycles - base), 64'd9);

    // Two-bit counter saturates while writes continue.
    cur = 2;
    base = wr_cycles;
    pulse_start();
    for (int r = 0; r < 5; r++) begin
      send_record(rand_addr(), $urandom, 1);
      check("sat_count_step", 64'(write_count[cur]), 64'((r + 1 > 3) ? 3 : r + 1));
    end
    send_end_word(1);
    check_done("saturate", 3);
    check("saturate_write_cycles", 64'(wr_cycles - base), 64'd5);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic send_end_word(input int g);
    send_word(DEF_END_ADDR, g);
  endtask

endmodule
